// File: rtl/instr_field_dispatcher_if.sv
// Bus bundle between the instruction dispatcher, its instruction memory and
// the downstream ALU-control consumer.
interface instr_field_dispatcher_if #(
   parameter int ADDR_W = 5
);
   logic              imem_en;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_rdata;
   logic              out_valid;
   logic              out_ready;
   logic [6:0]        funct7;
   logic [2:0]        funct3;
   logic [1:0]        alu_op;
   logic              illegal;
   logic [ADDR_W-1:0] index;

   modport master (
      output imem_en, imem_addr,
      input  imem_rdata,
      output out_valid,
      input  out_ready,
      output funct7, funct3, alu_op, illegal, index
   );

   modport slave (
      input  imem_en, imem_addr,
      output imem_rdata,
      input  out_valid,
      output out_ready,
      input  funct7, funct3, alu_op, illegal, index
   );
endinterface

// File: rtl/instr_field_dispatcher.sv
// Walks instruction memory once per start, decoding funct7/funct3/alu_op of
// each word and presenting it downstream on a valid/ready handshake.
module instr_field_dispatcher #(
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   instr_field_dispatcher_if.master  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_CAPTURE,
      S_PRESENT,
      S_DONE
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [6:0]        funct7_q, funct7_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [1:0]        alu_op_q, alu_op_d;
   logic              illegal_q, illegal_d;
   logic [ADDR_W-1:0] index_q, index_d;

   logic              last_word;
   logic              handshake;
   logic [1:0]        dec_alu_op;
   logic              dec_illegal;
   logic              unused_rdata;

   assign last_word    = (addr_q == ADDR_W'(DEPTH - 1));
   assign handshake    = (state_q == S_PRESENT) && bus.out_ready;
   assign unused_rdata = ^{bus.imem_rdata[24:15], bus.imem_rdata[11:7]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (start) state_d = S_FETCH;
         S_FETCH:   state_d = S_CAPTURE;
         S_CAPTURE: state_d = S_PRESENT;
         S_PRESENT: if (bus.out_ready) state_d = last_word ? S_DONE : S_FETCH;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.imem_en   = (state_q == S_FETCH);
      bus.imem_addr = (state_q == S_FETCH) ? addr_q : '0;
      bus.out_valid = (state_q == S_PRESENT);
      busy          = (state_q != S_IDLE);
      done          = (state_q == S_DONE);
   end

   // Unsupported opcodes still flow downstream, flagged illegal with alu_op 00.
   always_comb begin
      dec_alu_op  = 2'b00;
      dec_illegal = 1'b0;
      case (bus.imem_rdata[6:0])
         7'b0000011, 7'b0100011: dec_alu_op = 2'b00;
         7'b1100011:             dec_alu_op = 2'b01;
         7'b0110011:             dec_alu_op = 2'b10;
         7'b0010011:             dec_alu_op = 2'b11;
         default:                dec_illegal = 1'b1;
      endcase
   end

   always_comb begin
      addr_d    = addr_q;
      funct7_d  = funct7_q;
      funct3_d  = funct3_q;
      alu_op_d  = alu_op_q;
      illegal_d = illegal_q;
      index_d   = index_q;
      if ((state_q == S_IDLE) && start) begin
         addr_d = '0;
      end
      if (handshake && !last_word) begin
         addr_d = addr_q + 1'b1;
      end
      if (state_q == S_CAPTURE) begin
         funct7_d  = bus.imem_rdata[31:25];
         funct3_d  = bus.imem_rdata[14:12];
         alu_op_d  = dec_alu_op;
         illegal_d = dec_illegal;
         index_d   = addr_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q    <= '0;
         funct7_q  <= '0;
         funct3_q  <= '0;
         alu_op_q  <= '0;
         illegal_q <= 1'b0;
         index_q   <= '0;
      end else begin
         addr_q    <= addr_d;
         funct7_q  <= funct7_d;
         funct3_q  <= funct3_d;
         alu_op_q  <= alu_op_d;
         illegal_q <= illegal_d;
         index_q   <= index_d;
      end
   end

   assign bus.funct7  = funct7_q;
   assign bus.funct3  = funct3_q;
   assign bus.alu_op  = alu_op_q;
   assign bus.illegal = illegal_q;
   assign bus.index   = index_q;

endmodule
